crc_serial_param: RTL and testbench

- Parametrised bit-serial CRC engine; successor to the fixed 8-bit serial CRC blocks.
- Width, polynomial, init value and frame length are set by parameters.
- Two runtime modes:
  - generate: passes the data through and appends the computed CRC, MSB first;
  - check: consumes data plus received CRC and flags a match.
- Sits between a serial framer and the link; accepts one bit per cycle under a valid strobe.

---
 rtl/crc_serial_param.sv | 137 +++++++++++++
 tb/tb_crc_serial_param.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_param.sv
// Parametrised bit-serial CRC engine (direct method, MSB first).
// Generate mode echoes the payload and appends the CRC; check mode flags a zero remainder.
module crc_serial_param #(
  parameter int unsigned           WIDTH    = 8,
  parameter logic [WIDTH-1:0]      POLY     = 8'h07,
  parameter logic [WIDTH-1:0]      INIT     = '0,
  parameter int unsigned           DATA_LEN = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             mode,
  input  logic             in,
  input  logic             in_valid,
  output logic             busy,
  output logic             out,
  output logic             out_valid,
  output logic [WIDTH-1:0] CRC,
  output logic             done,
  output logic             crc_ok
);

  localparam int unsigned MaxLen = (DATA_LEN > WIDTH) ? DATA_LEN : WIDTH;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  typedef enum logic [1:0] {StIdle, StData, StTail, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  crc_q, crc_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              crc_ok_q, crc_ok_d;
  logic [WIDTH-1:0]  crc_upd;

  assign crc_upd = {crc_q[WIDTH-2:0], 1'b0} ^ ((in ^ crc_q[WIDTH-1]) ? POLY : '0);

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    crc_ok_d    = crc_ok_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          crc_d    = INIT;
          mode_d   = mode;
          crc_ok_d = 1'b0;
          cnt_d    = '0;
          state_d  = StData;
        end
      end
      StData: begin
        if (in_valid) begin
          crc_d = crc_upd;
          if (!mode_q) begin
            out_d       = in;
            out_valid_d = 1'b1;
          end
          if (cnt_q == CntW'(DATA_LEN - 1)) begin
            cnt_d   = '0;
            shift_d = crc_upd;
            state_d = StTail;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StTail: begin
        if (!mode_q) begin
          // CRC register stays frozen; the copy in shift_q is streamed out.
          out_d       = shift_q[WIDTH-1];
          out_valid_d = 1'b1;
          shift_d     = {shift_q[WIDTH-2:0], 1'b0};
          if (cnt_q == CntW'(WIDTH - 1)) begin
            cnt_d    = '0;
            crc_ok_d = 1'b0;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (in_valid) begin
          crc_d = crc_upd;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            cnt_d    = '0;
            crc_ok_d = (crc_upd == '0);
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      crc_q       <= INIT;
      shift_q     <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      crc_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      crc_ok_q    <= crc_ok_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign CRC       = crc_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign crc_ok    = crc_ok_q;

endmodule

// File: tb/tb_crc_serial_param.sv
// Bench for crc_serial_param: default CRC-8 instance plus a CRC-16/CCITT-FALSE instance,
// checked against a polynomial long-division reference.
module tb_crc_serial_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start8, mode8, in8, in_valid8;
  logic busy8, out8, out_valid8, done8, crc_ok8;
  logic [7:0] crc8;
  logic start16, mode16, in16, in_valid16;
  logic busy16, out16, out_valid16, done16, crc_ok16;
  logic [15:0] crc16;

  crc_serial_param dut8 (
    .CLK(clk), .RST(rst), .start(start8), .mode(mode8), .in(in8), .in_valid(in_valid8),
    .busy(busy8), .out(out8), .out_valid(out_valid8), .CRC(crc8), .done(done8),
    .crc_ok(crc_ok8)
  );

  crc_serial_param #(
    .WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .DATA_LEN(72)
  ) dut16 (
    .CLK(clk), .RST(rst), .start(start16), .mode(mode16), .in(in16), .in_valid(in_valid16),
    .busy(busy16), .out(out16), .out_valid(out_valid16), .CRC(crc16), .done(done16),
    .crc_ok(crc_ok16)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Remainder of (M(x)*x^w + init*x^L) mod G(x), by long division over a bit list.
  function automatic logic [31:0] ref_crc(input bit msg[$], input int unsigned w,
                                          input logic [31:0] poly, input logic [31:0] init);
    bit d[$];
    int l;
    logic [31:0] r;
    d = msg;
    l = msg.size();
    for (int i = 0; i < int'(w); i++) d.push_back(1'b0);
    for (int i = 0; i < int'(w); i++) d[i] = d[i] ^ init[w-1-i];
    for (int i = 0; i < l; i++)
      if (d[i]) for (int j = 1; j <= int'(w); j++) d[i+j] = d[i+j] ^ poly[w-j];
    r = '0;
    for (int j = 0; j < int'(w); j++) r[w-1-j] = d[l+j];
    return r;
  endfunction

  function automatic logic [7:0] payload_crc8(input logic [31:0] p);
    bit b[$];
    logic [31:0] r;
    for (int i = 31; i >= 0; i--) b.push_back(p[i]);
    r = ref_crc(b, 8, 32'h07, 32'h0);
    return r[7:0];
  endfunction

  // Caller must be at a negedge; start is driven immediately (back-to-back frames allowed).
  // stall: 0 none, 1 alternate, 2 random. pokes: pulse start and flip mode mid-frame.
  task automatic frame8(input bit m, input logic [31:0] payload, input logic [7:0] rx,
                        input int stall, input bit pokes,
                        output logic [7:0] got_crc, output bit got_ok);
    bit all[$];
    int acc[$];
    logic [31:0] r;
    logic [7:0] exp_crc;
    bit exp_ok;
    logic [63:0] exp_stream, got_stream;
    int exp_len, got_len, nbits, ec, done_edge, exp_edge;
    bit hold_bad, busy_bad;
    for (int i = 31; i >= 0; i--) all.push_back(payload[i]);
    if (m) for (int i = 7; i >= 0; i--) all.push_back(rx[i]);
    nbits = all.size();
    r = ref_crc(all, 8, 32'h07, 32'h0);
    exp_crc = r[7:0];
    exp_ok = m && (exp_crc == 8'h00);
    exp_stream = m ? 64'h0 : {24'h0, payload, exp_crc};
    exp_len = m ? 0 : 40;
    got_stream = '0; got_len = 0; done_edge = -1; hold_bad = 0; busy_bad = 0;
    got_crc = '0; got_ok = 0;

    start8 = 1'b1; mode8 = m;
    in_valid8 = 1'($urandom_range(0, 1)); in8 = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    chk("start_busy", 64'(busy8), 64'h1);
    ec = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit v;
      if (stall == 0) v = 1'b1;
      else if (stall == 1) v = (cyc % 2 == 0);
      else v = ($urandom_range(0, 2) != 0);
      start8 = pokes && ($urandom_range(0, 3) == 0);
      mode8 = 1'($urandom_range(0, 1));
      if (acc.size() < nbits) begin
        in_valid8 = v;
        in8 = v ? all[acc.size()] : 1'($urandom_range(0, 1));
        if (v) acc.push_back(ec + 1);
      end else begin
        in_valid8 = 1'($urandom_range(0, 1));
        in8 = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      ec++;
      @(negedge clk);
      if (!busy8) busy_bad = 1;
      if (out_valid8) begin
        got_stream = {got_stream[62:0], out8};
        got_len++;
      end
      if (!m && acc.size() == nbits && ec >= acc[nbits-1] && crc8 !== exp_crc) hold_bad = 1;
      if (done8) begin
        done_edge = ec; got_crc = crc8; got_ok = crc_ok8;
        break;
      end
    end
    start8 = 1'b0; in_valid8 = 1'b0;
    if (done_edge < 0) begin
      nvec++; nmis++;
      $display("FAIL done_timeout: got no done pulse expected done within 600 cycles");
      return;
    end
    chk("crc_final", 64'(got_crc), 64'(exp_crc));
    chk("crc_ok", 64'(got_ok), 64'(exp_ok));
    chk("out_len", 64'(got_len), 64'(exp_len));
    chk("out_bits", got_stream, exp_stream);
    chk("busy_in_frame", 64'(busy_bad), 64'h0);
    if (!m) chk("crc_hold_tail", 64'(hold_bad), 64'h0);
    exp_edge = m ? acc[nbits-1] : acc[31] + 8;
    chk("done_time", 64'(done_edge), 64'(exp_edge));
    // Counting the first-bit cycle as cycle 1.
    if (stall == 0) chk("latency", 64'(done_edge - acc[0] + 2), 64'd41);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", 64'(done8), 64'h0);
    chk("idle_after_done", 64'(busy8), 64'h0);
    chk("crc_ok_held", 64'(crc_ok8), 64'(exp_ok));
  endtask

  task automatic frame16(input bit m, input logic [15:0] rx,
                         output logic [15:0] got_crc, output bit got_ok);
    logic [71:0] p;
    bit all[$];
    logic [31:0] r;
    logic [15:0] exp_crc, tail;
    int idx, got_len;
    bit seen;
    p = "123456789";
    for (int i = 71; i >= 0; i--) all.push_back(p[i]);
    if (m) for (int i = 15; i >= 0; i--) all.push_back(rx[i]);
    r = ref_crc(all, 16, 32'h1021, 32'hFFFF);
    exp_crc = r[15:0];
    tail = '0; idx = 0; got_len = 0; seen = 0; got_crc = '0; got_ok = 0;
    start16 = 1'b1; mode16 = m;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (idx < all.size()) begin
        in16 = all[idx]; in_valid16 = 1'b1; idx++;
      end else begin
        in_valid16 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (out_valid16) begin
        tail = {tail[14:0], out16};
        got_len++;
      end
      if (done16) begin
        got_crc = crc16; got_ok = crc_ok16; seen = 1;
        break;
      end
    end
    in_valid16 = 1'b0;
    if (!seen) begin
      nvec++; nmis++;
      $display("FAIL done16_timeout: got no done pulse expected done within 300 cycles");
      return;
    end
    chk("crc16_model", 64'(got_crc), 64'(exp_crc));
    chk("crc16_ok_model", 64'(got_ok), 64'(m && exp_crc == 16'h0));
    chk("out16_len", 64'(got_len), m ? 64'd0 : 64'd88);
    if (!m) chk("out16_tail", 64'(tail), 64'(exp_crc));
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          m;
    logic [31:0] payload;
    logic [7:0]  rx;
    logic [7:0]  exp_crc;
    bit          exp_ok;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] gc;
    logic [15:0] gc16;
    bit go;
    bit saw_done, saw_busy;

    tbl[0] = '{m: 0, payload: 32'h0000000D, rx: 8'h00, exp_crc: 8'h23, exp_ok: 0};
    tbl[1] = '{m: 1, payload: 32'h0000000D, rx: 8'h23, exp_crc: 8'h00, exp_ok: 1};
    tbl[2] = '{m: 1, payload: 32'h0000000D, rx: 8'h22, exp_crc: 8'h07, exp_ok: 0};
    tbl[3] = '{m: 0, payload: 32'h00000000, rx: 8'h00, exp_crc: 8'h00, exp_ok: 0};
    tbl[4] = '{m: 1, payload: 32'h00000000, rx: 8'h00, exp_crc: 8'h00, exp_ok: 1};
    tbl[5] = '{m: 1, payload: 32'h00000000, rx: 8'h01, exp_crc: 8'h07, exp_ok: 0};

    rst = 1'b1;
    start8 = 0; mode8 = 0; in8 = 0; in_valid8 = 0;
    start16 = 0; mode16 = 0; in16 = 0; in_valid16 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy8), 64'h0);
    chk("rst_crc", 64'(crc8), 64'h0);
    chk("rst_out", 64'({out8, out_valid8, done8, crc_ok8}), 64'h0);
    chk("rst_crc16", 64'(crc16), 64'hFFFF);

    for (int i = 0; i < 6; i++) begin
      frame8(tbl[i].m, tbl[i].payload, tbl[i].rx, 0, 0, gc, go);
      chk($sformatf("tbl%0d_crc", i), 64'(gc), 64'(tbl[i].exp_crc));
      chk($sformatf("tbl%0d_ok", i), 64'(go), 64'(tbl[i].exp_ok));
    end

    frame8(0, 32'h0000000D, 8'h00, 1, 0, gc, go);
    chk("stall_toggle_crc", 64'(gc), 64'h23);
    frame8(0, 32'h0000000D, 8'h00, 0, 1, gc, go);
    chk("start_busy_gen_crc", 64'(gc), 64'h23);
    frame8(1, 32'h0000000D, 8'h23, 0, 1, gc, go);
    chk("start_busy_chk_ok", 64'(go), 64'h1);

    // Abort a frame after 10 bits; crc_ok is 1 from the preceding check frame.
    start8 = 1'b1; mode8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ab;
      ab = 32'hA5C30F0D;
      in8 = ab[31-i]; in_valid8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1; in8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid8 = 1'b0;
    chk("midrst_busy", 64'(busy8), 64'h0);
    chk("midrst_crc", 64'(crc8), 64'h0);
    chk("midrst_flags", 64'({out8, out_valid8, done8, crc_ok8}), 64'h0);
    saw_done = 0; saw_busy = 0;
    for (int i = 0; i < 50; i++) begin
      in_valid8 = 1'($urandom_range(0, 1)); in8 = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      if (done8) saw_done = 1;
      if (busy8) saw_busy = 1;
    end
    in_valid8 = 1'b0;
    chk("midrst_no_done", 64'(saw_done), 64'h0);
    chk("midrst_stays_idle", 64'(saw_busy), 64'h0);
    frame8(0, 32'h0000000D, 8'h00, 0, 0, gc, go);
    chk("after_rst_crc", 64'(gc), 64'h23);

    frame16(0, 16'h0000, gc16, go);
    chk("crc16_check_value", 64'(gc16), 64'h29B1);
    frame16(1, 16'h29B1, gc16, go);
    chk("crc16_chk_ok", 64'(go), 64'h1);
    chk("crc16_chk_zero", 64'(gc16), 64'h0);

    for (int k = 0; k < 40; k++) begin
      bit m;
      logic [31:0] p;
      logic [7:0] rx;
      m = 1'($urandom_range(0, 1));
      p = $urandom;
      rx = ($urandom_range(0, 1) != 0) ? payload_crc8(p) : 8'($urandom);
      frame8(m, p, rx, 2, 1, gc, go);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
